address_decoder: RTL
====================

# address_decoder

Address-phase decoder for the PCI slave, directly upstream of the device-select stage. It samples `ad`/`cbe` on the address phase of each transaction and compares the address against the slave's memory window. If the address hits and the command is supported, it drives the active-low claim signal `decoderOut` that the device-select stage delays into DEVSEL#. While the transaction is claimed, it also tracks the burst dword offset and direction for the data-path stages.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: window base; must be aligned to the window size.
- `WIN_LOG2`, default 4: window holds 2^WIN_LOG2 dwords (4·2^WIN_LOG2 bytes).
- `clk`  in  1: clock; all registers update on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `frame`  in  1: bus FRAME#, active-low.
- `irdy`  in  1: bus IRDY#, active-low.
- `trdy`  in  1: TRDY# as driven by this slave, active-low.
- `ad`  in  32: multiplexed address/data bus.
- `cbe`  in  4: command (address phase) / byte enables.
- `decoderOut`  out  1: claim, active-low; 0 = this slave owns the current transaction. Feeds `decoderInput` of the device-select stage.
- `cmdWrite`  out  1: 1 = memory write, 0 = memory read; valid while `decoderOut`=0.
- `wordIndex`  out  WIN_LOG2: current dword offset within the window.

## Operation
- State machine has four states: IDLE, CLAIMED, IGNORE, TURN.
- IDLE:
  - `frame`=0 marks the address phase.
  - Hit when `ad[31:WIN_LOG2+2] == BASE_ADDR[31:WIN_LOG2+2]` and `cbe` is CMD_MEM_READ (4'b0110) or CMD_MEM_WRITE (4'b0111).
  - On hit: go to CLAIMED; latch `cmdWrite` = `cbe[0]` and `wordIndex` = `ad[WIN_LOG2+1:2]`. `ad[1:0]` is ignored (linear burst only).
  - On miss or other command: go to IGNORE.
- CLAIMED:
  - `decoderOut`=0.
  - Each edge with `irdy`=0 and `trdy`=0 completes a data phase and increments `wordIndex` modulo 2^WIN_LOG2 (wrap-around, no abort).
  - Completed phase with `frame`=1 is the final phase: go to TURN.
  - `frame`=1 and `irdy`=1 (master abort / bus idle): go to IDLE.
- IGNORE: stay until `frame`=1 and `irdy`=1, then go to IDLE. Outputs are not updated.
- TURN: lasts exactly one cycle, then IDLE. `frame`=0 during TURN is not decoded; fast back-to-back is unsupported.
- Reset:
  - `rst`=1 forces IDLE, `decoderOut`=1, `cmdWrite`=0, `wordIndex`=0.
  - Reset overrides all other inputs, including mid-transaction.
- `decoderOut`=1 in every state except CLAIMED.

## Timing
- Claim latency is 1 cycle. If the address phase is at edge N, `decoderOut` falls after edge N and holds through CLAIMED.
- `decoderOut` returns to 1 after the edge that moves CLAIMED to TURN or to IDLE.
- `wordIndex` updates after the completing edge. The value visible during a data phase is the offset of that phase.
- If a data phase completes while `frame`=1 and the index is at 2^WIN_LOG2-1:
  - the index wraps to 0;
  - the state still goes to TURN.
- If `frame`=0 and `rst`=1 on the same edge, reset wins; no claim is made on that edge.
- Minimum spacing between claimed transactions: final phase edge, then TURN, then IDLE, so the next address phase is sampled 2 edges later at the earliest.

## Structure
- Shared package `pci_pkg` holds:
  - command codes CMD_MEM_READ and CMD_MEM_WRITE;
  - the decoder state enum (IDLE, CLAIMED, IGNORE, TURN).
- The device-select stage and future target stages import the same package.
- One sub-module, `burst_counter`:
  - WIN_LOG2-bit offset register;
  - inputs: load, load value, increment;
  - wraps at 2^WIN_LOG2.
- Address compare and the FSM live in `address_decoder` itself.

## Test plan
- Read hit, reset defaults (BASE 32'h1000, WIN_LOG2 4): `ad`=32'h0000_1008, `cbe`=4'b0110, `frame` 1→0 → `decoderOut`=0 one cycle later, `cmdWrite`=0, `wordIndex`=2.
- Write burst: `ad`=32'h0000_1000, `cbe`=4'b0111, four data phases with `irdy`=`trdy`=0, `frame`=1 on the fourth → `wordIndex` steps 0,1,2,3; then TURN; `decoderOut`=1 after the fourth edge.
- Wrap: `ad`=32'h0000_103C (offset 15), three completed phases → `wordIndex` 15,0,1; claim is held throughout.
- Misses:
  - `ad`=32'h0000_2000 with a read → `decoderOut` stays 1 for the whole transaction.
  - `ad`=32'h0000_1000 with `cbe`=4'b0010 (I/O read) → `decoderOut` stays 1.
- Stalls and abort:
  - `irdy`=1 stall cycles inside a burst → `wordIndex` holds.
  - `frame`=1, `irdy`=1 without a completed phase → IDLE, `decoderOut`=1.
- Reset mid-burst: `rst`=1 while CLAIMED at `wordIndex`=5 → next edge `decoderOut`=1, `wordIndex`=0, `cmdWrite`=0. A new address phase decodes normally after `rst` drops.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI target definitions: bus command codes and the address-decoder state encoding.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    CLAIMED,
    IGNORE,
    TURN
  } decoder_state_t;

  function automatic logic is_mem_cmd(input logic [3:0] cmd);
    return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
  endfunction

endpackage

// File: rtl/address_decoder_if.sv
// Address-phase bus signals seen by the decoder plus its claim/offset outputs.
interface address_decoder_if #(
  parameter int WIN_LOG2 = 4
);

  logic                frame;
  logic                irdy;
  logic                trdy;
  logic [31:0]         ad;
  logic [3:0]          cbe;
  logic                decoderOut;
  logic                cmdWrite;
  logic [WIN_LOG2-1:0] wordIndex;

  modport master (
    output frame, irdy, trdy, ad, cbe,
    input  decoderOut, cmdWrite, wordIndex
  );

  modport slave (
    input  frame, irdy, trdy, ad, cbe,
    output decoderOut, cmdWrite, wordIndex
  );

endinterface

// File: rtl/burst_counter.sv
// Dword offset register for a linear burst; wraps naturally at 2^WIN_LOG2.
module burst_counter #(
  parameter int WIN_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [WIN_LOG2-1:0] load_value,
  input  logic                inc,
  output logic [WIN_LOG2-1:0] offset
);

  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
    end else if (load) begin
      offset <= load_value;
    end else if (inc) begin
      offset <= offset + 1'b1;
    end
  end

endmodule

// File: rtl/address_decoder.sv
// PCI slave address-phase decoder: claims hits in the memory window and tracks burst offset.
module address_decoder
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          WIN_LOG2  = 4
) (
  input logic              clk,
  input logic              rst,
  address_decoder_if.slave bus
);

  localparam int TAG_LSB = WIN_LOG2 + 2;

  decoder_state_t      state;
  logic                hit;
  logic                phase_done;
  logic                load;
  logic                inc;
  logic                decoder_out;
  logic                cmd_write;
  logic [WIN_LOG2-1:0] offset;
  logic                unused_ad_low;

  // Byte lane bits carry no meaning for a linear burst.
  assign unused_ad_low = ^bus.ad[1:0];

  assign hit        = (bus.ad[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) && is_mem_cmd(bus.cbe);
  assign phase_done = !bus.irdy && !bus.trdy;
  assign load       = (state == IDLE) && !bus.frame && hit;
  assign inc        = (state == CLAIMED) && phase_done;

  burst_counter #(
    .WIN_LOG2(WIN_LOG2)
  ) u_burst_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(bus.ad[TAG_LSB-1:2]),
    .inc       (inc),
    .offset    (offset)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      decoder_out <= 1'b1;
      cmd_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.frame) begin
            if (hit) begin
              state       <= CLAIMED;
              decoder_out <= 1'b0;
              cmd_write   <= bus.cbe[0];
            end else begin
              state <= IGNORE;
            end
          end
        end
        CLAIMED: begin
          // A completed phase with FRAME# deasserted is the last one of the burst.
          if (phase_done && bus.frame) begin
            state       <= TURN;
            decoder_out <= 1'b1;
          end else if (bus.frame && bus.irdy) begin
            state       <= IDLE;
            decoder_out <= 1'b1;
          end
        end
        IGNORE: begin
          if (bus.frame && bus.irdy) begin
            state <= IDLE;
          end
        end
        TURN: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          decoder_out <= 1'b1;
        end
      endcase
    end
  end

  assign bus.decoderOut = decoder_out;
  assign bus.cmdWrite   = cmd_write;
  assign bus.wordIndex  = offset;

endmodule
